muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multi-cycle multiply/divide/modulo unit serving the processor's `ALU_MUL`, `ALU_DIV` and `ALU_MOD` operations. The issuing pipeline presents a request through a valid/ready handshake and the unit returns the result with a one-cycle done strobe. All arithmetic is unsigned 32-bit, with results identical to the single-cycle ALU's `*`, `/` and `%`. Opcode encodings come from `defs.v`.

## Interface

Parameters:
- `WIDTH`, 32: operand/result width. Iteration count equals `WIDTH`.

Ports:
- `i_clk`  in  1  clock; all state changes on rising edge
- `i_rst`  in  1  reset, synchronous, active-high
- `i_valid`  in  1  request present
- `i_ctl`  in  4  operation code; only `ALU_MUL`, `ALU_DIV`, `ALU_MOD` are legal
- `i_op1`  in  WIDTH  multiplicand / dividend
- `i_op2`  in  WIDTH  multiplier / divisor
- `o_ready`  out  1  unit can accept a request this cycle
- `o_done`  out  1  single-cycle strobe; `o_res` is valid
- `o_res`  out  WIDTH  result; held until the next acceptance

## Operation

- States: IDLE, RUN, DONE.
- Accept condition: `i_valid && o_ready && i_ctl` is legal. On accept:
  - latch `i_op1`, `i_op2` and `i_ctl`;
  - clear the accumulator/remainder;
  - load iteration counter = `WIDTH`-1;
  - go to RUN.
- Illegal `i_ctl` with `i_valid`: ignored. Not accepted, no state change, no `o_done`.
- `o_ready` = 1 in IDLE and DONE; 0 in RUN.
- MUL: shift-add, one multiplier bit per cycle, LSB first. Product accumulator is 2×`WIDTH`. `o_res` = low `WIDTH` bits of the product.
- DIV/MOD: restoring division, one quotient bit per cycle, MSB first.
  - Remainder register is `WIDTH`+1 bits to hold the trial-subtract borrow.
  - DIV returns the quotient; MOD returns the remainder.
- Divide by zero: no special casing. The restoring algorithm naturally yields quotient = all-ones (0xFFFFFFFF) and remainder = `i_op1`. These values are the required results.
- RUN: one iteration per cycle. When the counter reaches 0 and that iteration completes:
  - write the selected result to `o_res`;
  - go to DONE.
- DONE: `o_done` = 1 for exactly this cycle. Next state:
  - RUN if a new request is accepted this cycle;
  - otherwise IDLE.
- Operand or `i_ctl` changes after acceptance have no effect on the operation in flight.
- `i_valid` during RUN is ignored. The requester must hold the request until it sees `o_ready`.
- Reset (any state, including mid-RUN): next state IDLE; `o_done` = 0; `o_res` = 0; counter and working registers cleared. The in-flight operation is discarded, with no done strobe.

## Timing

- Reset values: `o_ready` = 1, `o_done` = 0, `o_res` = 0, state IDLE.
- Acceptance at rising edge E0.
- RUN occupies the cycles between E0 and E32, i.e. `WIDTH` iterations.
- `o_done` is high from E32 to E33. Latency from acceptance to done strobe = `WIDTH` cycles.
- Back-to-back: a request accepted at E33 (during DONE) strobes done at E65. Sustained throughput is one operation per `WIDTH`+1 cycles.
- `o_res` changes only on the edge entering DONE, and on reset. It is stable at all other times, including through IDLE and the next RUN.
- `o_ready`, `o_done` and `o_res` are registered or decoded only from state. There are no combinational paths from inputs to outputs.

## Test plan

- Basic multiply: MUL 7 × 6 accepted at E0 → `o_done` high exactly at cycle E32–E33; `o_res` = 42; `o_ready` low between E1 and E32.
- Multiply overflow: MUL 0xFFFFFFFF × 0xFFFFFFFF → `o_res` = 0x00000001. MUL 0x00010000 × 0x00010000 → `o_res` = 0x00000000.
- Divide and modulo:
  - DIV 100 / 7 → 14; MOD 100 % 7 → 2.
  - DIV 0x80000000 / 1 → 0x80000000.
  - MOD 5 % 9 → 5.
- Divide by zero: DIV 0x12345678 / 0 → 0xFFFFFFFF; MOD 0x12345678 % 0 → 0x12345678.
- Handshake:
  - Second request (DIV 100 / 7) presented during DONE of a MUL 3 × 4 is accepted in that cycle. `o_res` = 12 with the first strobe, then 14 exactly 33 cycles later.
  - `i_valid` pulses during RUN and operand changes after acceptance do not alter the result.
  - Illegal `i_ctl` (`ALU_ADD`) with `i_valid` → never accepted, no `o_done`.
- Reset mid-operation: assert `i_rst` for one cycle at E10 of a MUL → no `o_done` ever appears for that request; `o_res` = 0; `o_ready` = 1 on the following cycle. A fresh MUL 2 × 3 then completes with `o_res` = 6.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative unsigned mul/div/mod: shift-add multiply, restoring divide, one bit per cycle.
// Done strobe WIDTH cycles after acceptance; ready is low while an operation is running.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [3:0]       i_ctl,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  output logic             o_ready,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res
);

  // Opcode values mirror the processor's defs.v encodings
  localparam logic [3:0] ALU_MUL = 4'd10;
  localparam logic [3:0] ALU_DIV = 4'd11;
  localparam logic [3:0] ALU_MOD = 4'd12;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [3:0]           ctl;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     dq;
  logic [WIDTH-1:0]     dvs;
  logic [WIDTH-1:0]     rem;
  logic                 done;
  logic [WIDTH-1:0]     res;

  logic                 legal;
  logic                 accept;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;
  logic                 qbit;
  logic [WIDTH-1:0]     rem_nxt;
  logic [WIDTH-1:0]     dq_nxt;
  logic [WIDTH-1:0]     result;

  assign legal   = (i_ctl == ALU_MUL) || (i_ctl == ALU_DIV) || (i_ctl == ALU_MOD);
  assign o_ready = (state != RUN);
  assign accept  = i_valid && o_ready && legal;
  assign o_done  = done;
  assign o_res   = res;

  // The WIDTH+1-bit trial difference carries the borrow that decides each quotient bit
  always_comb begin
    acc_nxt = mplier[0] ? acc + mcand : acc;
    shifted = {rem, dq[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    qbit    = ~diff[WIDTH];
    rem_nxt = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dq_nxt  = {dq[WIDTH-2:0], qbit};
    if (ctl == ALU_MUL)      result = acc_nxt[WIDTH-1:0];
    else if (ctl == ALU_DIV) result = dq_nxt;
    else                     result = rem_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      ctl    <= '0;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      dq     <= '0;
      dvs    <= '0;
      rem    <= '0;
      done   <= 1'b0;
      res    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          rem    <= rem_nxt;
          dq     <= dq_nxt;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            res   <= result;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          if (accept) begin
            ctl    <= i_ctl;
            mcand  <= {{WIDTH{1'b0}}, i_op1};
            mplier <= i_op2;
            dq     <= i_op1;
            dvs    <= i_op2;
            acc    <= '0;
            rem    <= '0;
            cnt    <= CW'(WIDTH - 1);
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: vector table plus handshake, reset and corner-case sequences.
module tb_muldiv_seq;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_MUL = 4'd10;
  localparam logic [3:0] ALU_DIV = 4'd11;
  localparam logic [3:0] ALU_MOD = 4'd12;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [3:0]  i_ctl = '0;
  logic [31:0] i_op1 = '0;
  logic [31:0] i_op2 = '0;
  logic        o_ready;
  logic        o_done;
  logic [31:0] o_res;

  muldiv_seq #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_ctl(i_ctl),
    .i_op1(i_op1), .i_op2(i_op2), .o_ready(o_ready), .o_done(o_done), .o_res(o_res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } sb_t;

  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   prev_done = 0;
  int   last_done = 0;
  int   n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every done strobe must match the oldest outstanding request
  always @(negedge clk) begin
    if (o_done) begin
      n_done++;
      prev_done = last_done;
      last_done = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%h expected=no_strobe", o_res);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("result", o_res, e.res);
        chk("latency", 32'(cyc - e.cyc), 32'd32);
      end
    end
  end

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    int n = 0;
    @(negedge clk);
    i_valid = 1'b1; i_ctl = c; i_op1 = a; i_op2 = b;
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("issue_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    sb.push_back('{res: exp, cyc: cyc});
  endtask

  // Waits for outstanding results; ready must stay low until the strobe cycle
  task automatic drain(input string name);
    int n = 0;
    int bad = 0;
    while (n < 200) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
      if (o_ready) bad++;
      n++;
    end
    chk({name, "_ready_low_in_run"}, 32'(bad), 32'd0);
    chk({name, "_drain"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{ALU_MUL, 32'd7,          32'd6,          32'd42};
    vecs[1] = '{ALU_MUL, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001};
    vecs[2] = '{ALU_MUL, 32'h00010000,   32'h00010000,   32'h00000000};
    vecs[3] = '{ALU_DIV, 32'd100,        32'd7,          32'd14};
    vecs[4] = '{ALU_MOD, 32'd100,        32'd7,          32'd2};
    vecs[5] = '{ALU_DIV, 32'h80000000,   32'd1,          32'h80000000};
    vecs[6] = '{ALU_MOD, 32'd5,          32'd9,          32'd5};
    vecs[7] = '{ALU_DIV, 32'h12345678,   32'd0,          32'hFFFFFFFF};
    vecs[8] = '{ALU_MOD, 32'h12345678,   32'd0,          32'h12345678};

    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(o_ready), 32'd1);
    chk("reset_done", 32'(o_done), 32'd0);
    chk("reset_res", o_res, 32'd0);

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].exp);
      drain($sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_res_held", i), o_res, vecs[i].exp);
    end

    // Back-to-back: DIV held through the MUL's RUN is taken during its DONE cycle
    issue(ALU_MUL, 32'd3, 32'd4, 32'd12);
    issue(ALU_DIV, 32'd100, 32'd7, 32'd14);
    drain("b2b");
    chk("b2b_gap", 32'(last_done - prev_done), 32'd33);

    // Operand/ctl churn and valid pulses during RUN must not disturb the result
    issue(ALU_MUL, 32'd1234, 32'd5678, 32'd7006652);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      i_valid = i[0];
      i_ctl   = ALU_DIV;
      i_op1   = $urandom;
      i_op2   = $urandom;
    end
    @(negedge clk);
    i_valid = 1'b0;
    drain("churn");

    // Illegal opcode is never accepted
    begin
      int bad = 0;
      int d0;
      d0 = n_done;
      @(negedge clk);
      i_valid = 1'b1; i_ctl = ALU_ADD; i_op1 = 32'd1; i_op2 = 32'd2;
      repeat (40) begin
        @(negedge clk);
        if (!o_ready || o_done) bad++;
      end
      i_valid = 1'b0;
      chk("illegal_ignored", 32'(bad), 32'd0);
      chk("illegal_no_done", 32'(n_done - d0), 32'd0);
      chk("illegal_res_held", o_res, 32'd7006652);
    end

    // Reset at E10 of a MUL discards it silently
    begin
      int d0;
      issue(ALU_MUL, 32'hFFFF, 32'hFFFF, 32'hFFFE0001);
      repeat (9) @(posedge clk);
      #1 i_rst = 1'b1;
      @(posedge clk);
      #1 i_rst = 1'b0;
      sb.delete();
      d0 = n_done;
      @(negedge clk);
      chk("rst_mid_res", o_res, 32'd0);
      chk("rst_mid_ready", 32'(o_ready), 32'd1);
      chk("rst_mid_done", 32'(o_done), 32'd0);
      repeat (40) @(negedge clk);
      chk("rst_mid_no_done", 32'(n_done - d0), 32'd0);
    end
    issue(ALU_MUL, 32'd2, 32'd3, 32'd6);
    drain("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
